// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results take the register-file write port first, and
// long-latency results queue in a FIFO that drains into idle write slots.
// Optional feature macro: WB_PENDING_MASK_EN (builds the pending_mask decode).
module wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [31:0]              alu_data,
    input  logic                     lu_valid,
    output logic                     lu_ready,
    input  logic [4:0]               lu_rd,
    input  logic [31:0]              lu_data,
    output logic                     reg_write,
    output logic [4:0]               write_addr,
    output logic [31:0]              write_data,
    output logic                     stall_req,
    output logic [31:0]              pending_mask,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO   = CW'(1'b0);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1'b1);
    localparam logic [PW-1:0] PTR_ZERO   = PW'(1'b0);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1'b1);
    localparam logic [SW-1:0] STARVE_C   = SW'(STARVE_LIMIT);
    localparam logic [SW-1:0] STARVE_ZERO = SW'(1'b0);
    localparam logic [SW-1:0] STARVE_ONE = SW'(1'b1);

    logic [4:0]    fifo_rd_q   [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          stall_q, stall_d;
    logic          reg_write_q, reg_write_d;
    logic [4:0]    write_addr_q, write_addr_d;
    logic [31:0]   write_data_q, write_data_d;

    logic          alu_busy_s;
    logic          fifo_empty_s;
    logic          lu_ready_s;
    logic          push_s;
    logic          pop_s;
    logic [31:0]   pending_s;

    // Handshake and slot arbitration decisions for this cycle.
    always_comb begin
        alu_busy_s   = alu_valid && (alu_rd != 5'd0);
        fifo_empty_s = (count_q == CNT_ZERO);
        lu_ready_s   = (count_q < DEPTH_C);
        push_s       = lu_valid && lu_ready_s && (lu_rd != 5'd0);
        pop_s        = !alu_busy_s && !fifo_empty_s;
    end

    // Next-state for FIFO bookkeeping, output stage and starvation tracking.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        reg_write_d  = 1'b0;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        starve_d     = starve_q;
        stall_d      = 1'b0;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (alu_busy_s) begin
            reg_write_d  = 1'b1;
            write_addr_d = alu_rd;
            write_data_d = alu_data;
        end else if (pop_s) begin
            reg_write_d  = 1'b1;
            write_addr_d = fifo_rd_q[rd_ptr_q];
            write_data_d = fifo_data_q[rd_ptr_q];
        end else begin
            reg_write_d  = 1'b0;
            write_addr_d = write_addr_q;
            write_data_d = write_data_q;
        end

        // A non-empty FIFO that is not popped can only mean the ALU held the slot.
        if (pop_s || fifo_empty_s) begin
            starve_d = STARVE_ZERO;
        end else if (starve_q != STARVE_C) begin
            starve_d = starve_q + STARVE_ONE;
        end else begin
            starve_d = starve_q;
        end

        stall_d = (starve_d == STARVE_C);
    end

    // FIFO storage; entries are written only on an accepted non-x0 push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_rd_q[i]   <= 5'd0;
                fifo_data_q[i] <= 32'd0;
            end
        end else if (push_s) begin
            fifo_rd_q[wr_ptr_q]   <= lu_rd;
            fifo_data_q[wr_ptr_q] <= lu_data;
        end
    end

    // Control state and registered write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= PTR_ZERO;
            rd_ptr_q     <= PTR_ZERO;
            count_q      <= CNT_ZERO;
            starve_q     <= STARVE_ZERO;
            stall_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            write_addr_q <= 5'd0;
            write_data_q <= 32'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            starve_q     <= starve_d;
            stall_q      <= stall_d;
            reg_write_q  <= reg_write_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
        end
    end

`ifdef WB_PENDING_MASK_EN
    logic [PW-1:0] pm_idx_s;

    // OR of one-hot destinations over the occupied span starting at the head.
    always_comb begin
        pending_s = 32'd0;
        pm_idx_s  = PTR_ZERO;
        for (int k = 0; k < DEPTH; k++) begin
            pm_idx_s = rd_ptr_q + PW'(k);
            if (CW'(k) < count_q) begin
                pending_s = pending_s | (32'd1 << fifo_rd_q[pm_idx_s]);
            end else begin
                pending_s = pending_s;
            end
        end
    end
`else
    assign pending_s = 32'd0;
`endif

    assign lu_ready     = lu_ready_s;
    assign reg_write    = reg_write_q;
    assign write_addr   = write_addr_q;
    assign write_data   = write_data_q;
    assign stall_req    = stall_q;
    assign pending_mask = pending_s;
    assign fifo_count   = count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: hand-computed vector table, directed
// multi-cycle sequences, and a queue-based reference model feeding a scoreboard.
module tb_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;
`ifdef WB_PENDING_MASK_EN
    localparam bit PM_EN = 1'b1;
`else
    localparam bit PM_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        reg_write;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        stall_req;
    logic [31:0] pending_mask;
    logic [2:0]  fifo_count;

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
        .reg_write(reg_write), .write_addr(write_addr), .write_data(write_data),
        .stall_req(stall_req), .pending_mask(pending_mask), .fifo_count(fifo_count)
    );

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        int          count;
        logic        ready;
        logic        stall;
        logic [31:0] pmask;
    } exp_t;

    typedef struct {
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lr;
        logic [31:0] ld;
        logic        ewe;
        logic [4:0]  eaddr;
        int          ecount;
    } vec_t;

    exp_t        sb_q[$];
    logic [36:0] m_q[$];
    int          m_starve;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: advance by one clock edge using the current inputs.
    task automatic model_step();
        bit          busy, empty, ready;
        logic [36:0] h;
        logic [31:0] pm;
        exp_t        e;
        busy  = alu_valid && (alu_rd != 5'd0);
        empty = (m_q.size() == 0);
        ready = (m_q.size() < DEPTH);
        e.we  = 1'b0;
        if (busy) begin
            e.we = 1'b1; m_addr = alu_rd; m_data = alu_data;
        end else if (!empty) begin
            h = m_q.pop_front();
            e.we = 1'b1; m_addr = h[36:32]; m_data = h[31:0];
        end
        if (lu_valid && ready && lu_rd != 5'd0) m_q.push_back({lu_rd, lu_data});
        if (empty || !busy) m_starve = 0;
        else if (m_starve < LIMIT) m_starve++;
        pm = 32'd0;
        foreach (m_q[i]) pm = pm | (32'd1 << m_q[i][36:32]);
        e.addr  = m_addr;
        e.data  = m_data;
        e.count = m_q.size();
        e.ready = (m_q.size() < DEPTH);
        e.stall = (m_starve == LIMIT);
        e.pmask = PM_EN ? pm : 32'd0;
        sb_q.push_back(e);
    endtask

    task automatic cycle(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lr, input logic [31:0] ld);
        exp_t e;
        alu_valid = av; alu_rd = ar; alu_data = ad;
        lu_valid  = lv; lu_rd  = lr; lu_data  = ld;
        model_step();
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk("reg_write",    {31'd0, reg_write}, {31'd0, e.we});
            chk("write_addr",   {27'd0, write_addr}, {27'd0, e.addr});
            chk("write_data",   write_data, e.data);
            chk("fifo_count",   {29'd0, fifo_count}, 32'(e.count));
            chk("lu_ready",     {31'd0, lu_ready}, {31'd0, e.ready});
            chk("stall_req",    {31'd0, stall_req}, {31'd0, e.stall});
            chk("pending_mask", pending_mask, e.pmask);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        sb_q.delete();
        m_starve = 0;
        m_addr   = 5'd0;
        m_data   = 32'd0;
    endtask

    vec_t vt[9];

    initial begin
        vt[0] = '{1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0,        1'b1, 5'd3, 0};
        vt[1] = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,        1'b0, 5'd3, 0};
        vt[2] = '{1'b0, 5'd0, 32'd0,        1'b1, 5'd8, 32'h12345678, 1'b0, 5'd3, 1};
        vt[3] = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,        1'b1, 5'd8, 0};
        vt[4] = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,        1'b0, 5'd8, 0};
        vt[5] = '{1'b1, 5'd0, 32'h0BADF00D, 1'b1, 5'd0, 32'hCAFEF00D, 1'b0, 5'd8, 0};
        vt[6] = '{1'b1, 5'd5, 32'h55555555, 1'b1, 5'd9, 32'h99999999, 1'b1, 5'd5, 1};
        vt[7] = '{1'b1, 5'd0, 32'h77777777, 1'b0, 5'd0, 32'd0,        1'b1, 5'd9, 0};
        vt[8] = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,        1'b0, 5'd9, 0};

        model_clear();
        reset = 1'b1;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        lu_valid = 1'b0; lu_rd = 5'd0; lu_data = 32'd0;
        #2;
        chk("rst_reg_write",  {31'd0, reg_write}, 32'd0);
        chk("rst_write_addr", {27'd0, write_addr}, 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        chk("rst_lu_ready",   {31'd0, lu_ready}, 32'd1);
        chk("rst_stall",      {31'd0, stall_req}, 32'd0);
        chk("rst_pending",    pending_mask, 32'd0);
        chk("rst_count",      {29'd0, fifo_count}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Table: ALU pass-through, uncontended LU, x0 no-ops, mixed slot.
        for (int i = 0; i < 9; i++) begin
            if (i == 5) chk("tbl_lu_ready_x0", {31'd0, lu_ready}, 32'd1);
            cycle(vt[i].av, vt[i].ar, vt[i].ad, vt[i].lv, vt[i].lr, vt[i].ld);
            chk($sformatf("tbl%0d_we", i),    {31'd0, reg_write}, {31'd0, vt[i].ewe});
            chk($sformatf("tbl%0d_addr", i),  {27'd0, write_addr}, {27'd0, vt[i].eaddr});
            chk($sformatf("tbl%0d_count", i), {29'd0, fifo_count}, 32'(vt[i].ecount));
            if (i == 0) chk("tbl0_data", write_data, 32'hDEADBEEF);
            if (i == 2) chk("tbl2_pmask", pending_mask, PM_EN ? 32'h0000_0100 : 32'd0);
            if (i == 3) chk("tbl3_data", write_data, 32'h12345678);
            if (i == 3) chk("tbl3_pmask", pending_mask, 32'd0);
        end

        // Fill FIFO under a permanently busy ALU, then watch starvation build.
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 5'(i + 1), 32'hA000_0000 + 32'(i), 1'b1, 5'(10 + i), 32'hB000_0000 + 32'(i));
        chk("full_ready", {31'd0, lu_ready}, 32'd0);
        chk("full_count", {29'd0, fifo_count}, 32'd4);
        chk("full_pmask", pending_mask, PM_EN ? 32'h0000_3C00 : 32'd0);
        for (int j = 0; j < 7; j++) begin
            cycle(1'b1, 5'd2, 32'hC000_0000 + 32'(j), 1'b1, 5'd20, 32'hD0D0D0D0);
            if (j == 3) chk("stall_7_blocked", {31'd0, stall_req}, 32'd0);
            if (j == 4) chk("stall_8_blocked", {31'd0, stall_req}, 32'd1);
            if (j == 6) chk("stall_saturated", {31'd0, stall_req}, 32'd1);
        end

        // Drain: pop while full and offered; push is refused, accepted next cycle.
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'hD0D0D0D0);
        chk("drain0_addr",  {27'd0, write_addr}, 32'd10);
        chk("drain0_data",  write_data, 32'hB000_0000);
        chk("drain0_count", {29'd0, fifo_count}, 32'd3);
        chk("drain0_ready", {31'd0, lu_ready}, 32'd1);
        chk("drain0_stall", {31'd0, stall_req}, 32'd0);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'hD0D0D0D0);
        chk("drain1_addr",  {27'd0, write_addr}, 32'd11);
        chk("drain1_count", {29'd0, fifo_count}, 32'd3);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("drain2_addr",  {27'd0, write_addr}, 32'd12);
        chk("drain2_we",    {31'd0, reg_write}, 32'd1);

        // Asynchronous reset in the middle of the drain.
        reset = 1'b1;
        #1;
        chk("midrst_count",   {29'd0, fifo_count}, 32'd0);
        chk("midrst_we",      {31'd0, reg_write}, 32'd0);
        chk("midrst_addr",    {27'd0, write_addr}, 32'd0);
        chk("midrst_ready",   {31'd0, lu_ready}, 32'd1);
        chk("midrst_pending", pending_mask, 32'd0);
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("post_rst_we", {31'd0, reg_write}, 32'd0);

        // Random traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  $urandom(),
                  ($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  $urandom());
        end
        for (int n = 0; n < 8; n++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("final_count", {29'd0, fifo_count}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
